// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the bit-serial ALU.
//   - op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR), 2 bits wide
//   - controller state encoding (IDLE, RUN, FIN)
//   - slices_ok(): elaboration-time check that WIDTH is a legal multiple of SLICES
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // True when the operand width can be walked in whole slices.
    function automatic bit slices_ok(input int width, input int slices);
        return (width >= 2) && (slices >= 1) && (slices <= width) &&
               ((width % slices) == 0);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational SLICES-bit ALU slice.
//   a, b   : operand slices
//   cin    : carry in from the previous slice (carry register)
//   op     : operation; SUB inverts b here so the caller only seeds cin=1
//   res    : slice result
//   cout   : carry out of the slice (0 for AND/OR)
//   c_msb  : carry into the top bit of the slice, used for signed overflow
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICES = 1
) (
    input  logic [SLICES-1:0] a,
    input  logic [SLICES-1:0] b,
    input  logic              cin,
    input  logic [1:0]        op,
    output logic [SLICES-1:0] res,
    output logic              cout,
    output logic              c_msb
);

    logic [SLICES-1:0] b_eff;
    logic [SLICES-1:0] sum;
    logic              carry;
    logic              c_top;

    // Ripple through the slice with a running variable rather than a carry
    // vector, so no vector feeds back into itself combinationally.
    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        carry = cin;
        c_top = cin;
        sum   = '0;
        for (int i = 0; i < SLICES; i++) begin
            if (i == SLICES - 1) begin
                c_top = carry;
            end
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end

        res   = sum;
        cout  = carry;
        c_msb = c_top;
        if (op == OP_AND) begin
            res   = a & b;
            cout  = 1'b0;
            c_msb = 1'b0;
        end else if (op == OP_OR) begin
            res   = a | b;
            cout  = 1'b0;
            c_msb = 1'b0;
        end
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ALU processing WIDTH-bit operands SLICES bits per
// clock, LSB first, through one alu_slice. N = WIDTH/SLICES cycles per op.
//   clk    : clock, all state changes on the rising edge
//   rstn   : synchronous active-low reset
//   start  : request, accepted when not busy (also in the done cycle)
//   op     : 00 ADD, 01 SUB, 10 AND, 11 OR, captured with start
//   a, b   : operands, captured with start
//   busy   : operation in progress
//   done   : one-cycle pulse when res/flags update
//   res    : result, held until the next completion
//   cout   : final carry (SUB: 1 = no borrow), 0 for AND/OR
//   ovf    : signed overflow for ADD/SUB, 0 for AND/OR
//   zero   : res == 0
//   neg    : res MSB
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SLICES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N     = WIDTH / SLICES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (!slices_ok(WIDTH, SLICES)) begin : g_param_check
            $error("alu_serial: WIDTH must be >= 2 and a multiple of SLICES");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  a_sh_reg, b_sh_reg, acc_reg;
    logic [1:0]        op_reg;
    logic              carry_reg;
    logic [WIDTH-1:0]  res_reg;
    logic              cout_reg, ovf_reg, zero_reg, neg_reg;

    logic [SLICES-1:0] s_res;
    logic              s_cout, s_cmsb;
    logic [WIDTH-1:0]  acc_shift;
    logic              accept, last, arith;

    alu_slice #(.SLICES(SLICES)) u_slice (
        .a     (a_sh_reg[SLICES-1:0]),
        .b     (b_sh_reg[SLICES-1:0]),
        .cin   (carry_reg),
        .op    (op_reg),
        .res   (s_res),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // New slice bits enter at the top; after N shifts slice 0 sits at the LSB.
    assign acc_shift = (acc_reg >> SLICES) | (WIDTH'(s_res) << (WIDTH - SLICES));
    assign accept    = start && (state_reg != RUN);
    assign last      = (state_reg == RUN) && (cnt_reg == LAST);
    assign arith     = (op_reg == OP_ADD) || (op_reg == OP_SUB);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == LAST) state_next = FIN;
            FIN:     state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg   <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            acc_reg   <= '0;
            op_reg    <= OP_ADD;
            carry_reg <= 1'b0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            op_reg    <= op;
            cnt_reg   <= '0;
            // SUB is A + ~B + 1: the +1 comes in as the initial carry.
            carry_reg <= (op == OP_SUB);
        end else if (state_reg == RUN) begin
            a_sh_reg  <= a_sh_reg >> SLICES;
            b_sh_reg  <= b_sh_reg >> SLICES;
            acc_reg   <= acc_shift;
            carry_reg <= s_cout;
            cnt_reg   <= cnt_reg + 1'b1;
            if (last) begin
                res_reg  <= acc_shift;
                cout_reg <= s_cout;
                ovf_reg  <= arith ? (s_cmsb ^ s_cout) : 1'b0;
                zero_reg <= (acc_shift == '0);
                neg_reg  <= acc_shift[WIDTH-1];
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == FIN);
    assign res  = res_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = zero_reg;
    assign neg  = neg_reg;

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: four alu_serial instances (8/1, 8/4, 16/2, 8/8) driven by
// directed steps plus a random run on the 16/2 instance, checked against a
// queue of model results.
module tb_alu_serial;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start_v [4];
    logic [1:0]  op_v    [4];
    logic [15:0] a_v     [4];
    logic [15:0] b_v     [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        cout_v  [4];
    logic        ovf_v   [4];
    logic        zero_v  [4];
    logic        neg_v   [4];
    logic [15:0] res_v   [4];

    exp_t q[$];
    exp_t prev [4];
    int   tests = 0;
    int   fails = 0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            localparam int W = (gi == 2) ? 16 : 8;
            localparam int S = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 2 : 8;
            logic         busy, done, cout, ovf, zero, neg;
            logic [W-1:0] res;
            alu_serial #(.WIDTH(W), .SLICES(S)) u_dut (
                .clk   (clk),
                .rstn  (rstn),
                .start (start_v[gi]),
                .op    (op_v[gi]),
                .a     (a_v[gi][W-1:0]),
                .b     (b_v[gi][W-1:0]),
                .busy  (busy),
                .done  (done),
                .res   (res),
                .cout  (cout),
                .ovf   (ovf),
                .zero  (zero),
                .neg   (neg)
            );
            assign busy_v[gi] = busy;
            assign done_v[gi] = done;
            assign res_v[gi]  = 16'(res);
            assign cout_v[gi] = cout;
            assign ovf_v[gi]  = ovf;
            assign zero_v[gi] = zero;
            assign neg_v[gi]  = neg;
        end
    endgenerate

    function automatic int wid(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic int ncyc(input int d);
        case (d)
            0:       return 8;
            1:       return 2;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference: whole-word arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [1:0] o,
                                   input logic [15:0] x_in, input logic [15:0] y_in);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask, x, y;
        int          m;
        m    = w - 1;
        mask = 16'((17'h1 << w) - 17'h1);
        x    = x_in & mask;
        y    = y_in & mask;
        e    = '0;
        full = '0;
        case (o)
            2'b00: begin
                full   = {1'b0, x} + {1'b0, y};
                e.res  = full[15:0] & mask;
                e.cout = full[w];
                e.ovf  = (x[m] == y[m]) && (e.res[m] != x[m]);
            end
            2'b01: begin
                e.res  = (x - y) & mask;
                e.cout = (x >= y);
                e.ovf  = (x[m] != y[m]) && (e.res[m] != x[m]);
            end
            2'b10:   e.res = x & y;
            default: e.res = x | y;
        endcase
        e.zero = (e.res == 16'h0);
        e.neg  = e.res[m];
        return e;
    endfunction

    function automatic exp_t sample(input int d);
        exp_t s;
        s.res  = res_v[d];
        s.cout = cout_v[d];
        s.ovf  = ovf_v[d];
        s.zero = zero_v[d];
        s.neg  = neg_v[d];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic compare_out(input int d);
        exp_t e, s;
        chk("sb_nonempty", 16'(q.size() > 0), 16'h1);
        e = (q.size() > 0) ? q.pop_front() : '0;
        s = sample(d);
        $display("[TB] dut%0d res=%h cout=%b ovf=%b zero=%b neg=%b (exp res=%h)",
                 d, s.res, s.cout, s.ovf, s.zero, s.neg, e.res);
        chk("res",  s.res,  e.res);
        chk("cout", 16'(s.cout), 16'(e.cout));
        chk("ovf",  16'(s.ovf),  16'(e.ovf));
        chk("zero", 16'(s.zero), 16'(e.zero));
        chk("neg",  16'(s.neg),  16'(e.neg));
        prev[d] = s;
    endtask

    // One operation. already: start was driven at the previous done sample.
    // poke: pulse start with other operands mid-run. chain: hold start in the
    // done cycle with the second operand set.
    task automatic run_op(input int d, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input bit already, input bit poke,
                          input bit chain, input logic [1:0] o2,
                          input logic [15:0] x2, input logic [15:0] y2);
        int lat;
        bit stable;
        if (!already) begin
            @(negedge clk);
            chk("idle_busy", 16'(busy_v[d]), 16'h0);
            chk("done_pulse", 16'(done_v[d]), 16'h0);
            op_v[d] = o; a_v[d] = x; b_v[d] = y; start_v[d] = 1'b1;
            q.push_back(model(wid(d), o, x, y));
        end
        @(negedge clk);
        start_v[d] = 1'b0;
        op_v[d] = 2'($urandom); a_v[d] = 16'($urandom); b_v[d] = 16'($urandom);
        chk("busy", 16'(busy_v[d]), 16'h1);
        lat = 0;
        stable = 1'b1;
        while (!done_v[d] && lat < ncyc(d) + 4) begin
            if (sample(d) !== prev[d]) stable = 1'b0;
            if (poke && lat == 1) begin
                start_v[d] = 1'b1; op_v[d] = 2'b00;
                a_v[d] = 16'h0011; b_v[d] = 16'h0022;
            end else begin
                start_v[d] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 16'(lat), 16'(ncyc(d)));
        chk("stable", 16'(stable), 16'h1);
        chk("busy_fin", 16'(busy_v[d]), 16'h0);
        compare_out(d);
        if (chain) begin
            op_v[d] = o2; a_v[d] = x2; b_v[d] = y2; start_v[d] = 1'b1;
            q.push_back(model(wid(d), o2, x2, y2));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        rstn = 1'b0;
        for (int d = 0; d < 4; d++) begin
            start_v[d] = 1'b1;   // reset must win over start
            op_v[d] = 2'b00; a_v[d] = 16'h00FF; b_v[d] = 16'h00FF;
            prev[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_busy", 16'(busy_v[d]), 16'h0);
            chk("rst_done", 16'(done_v[d]), 16'h0);
            chk("rst_res", res_v[d], 16'h0);
            chk("rst_flags", {12'h0, cout_v[d], ovf_v[d], zero_v[d], neg_v[d]}, 16'h0);
            start_v[d] = 1'b0;
        end
        rstn = 1'b1;

        // 8-bit, one bit per cycle
        run_op(0, 2'b00, 16'h7F, 16'h01, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        run_op(0, 2'b01, 16'h05, 16'h05, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        run_op(0, 2'b01, 16'h03, 16'h05, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        run_op(0, 2'b10, 16'hF0, 16'h3C, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        run_op(0, 2'b11, 16'hF0, 16'h3C, 0, 1, 0, 2'b00, 16'h0, 16'h0);
        run_op(0, 2'b00, 16'h10, 16'h20, 0, 0, 1, 2'b01, 16'h40, 16'h50);
        run_op(0, 2'b00, 16'h00, 16'h00, 1, 0, 0, 2'b00, 16'h0, 16'h0);

        // Reset during RUN: no completion, everything cleared
        @(negedge clk);
        op_v[0] = 2'b11; a_v[0] = 16'hAA; b_v[0] = 16'h55; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("abort_busy", 16'(busy_v[0]), 16'h0);
        chk("abort_res", res_v[0], 16'h0);
        chk("abort_flags", {12'h0, cout_v[0], ovf_v[0], zero_v[0], neg_v[0]}, 16'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_v[0] || busy_v[0]) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 16'(saw_done), 16'h0);
        for (int d = 0; d < 4; d++) prev[d] = '0;
        run_op(0, 2'b01, 16'h80, 16'h01, 0, 0, 0, 2'b00, 16'h0, 16'h0);

        // 8-bit, four bits per cycle
        run_op(1, 2'b00, 16'hFF, 16'h01, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        run_op(1, 2'b01, 16'h80, 16'h01, 0, 0, 1, 2'b11, 16'h0F, 16'h30);
        run_op(1, 2'b00, 16'h00, 16'h00, 1, 0, 0, 2'b00, 16'h0, 16'h0);

        // 8-bit, whole word in one cycle
        run_op(3, 2'b00, 16'h7F, 16'h01, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        run_op(3, 2'b01, 16'h03, 16'h05, 0, 0, 0, 2'b00, 16'h0, 16'h0);

        // 16-bit, two bits per cycle, random
        for (int i = 0; i < 1000; i++) begin
            run_op(2, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   0, 0, 0, 2'b00, 16'h0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
